// File: rtl/tnn_vote_seq.sv
// Ternary-NN vote sequencer: accumulates positive/negative operand groups over
// a multi-beat vote, then registers a saturating magnitude comparison.
module tnn_vote_seq #(
  parameter int W     = 2,
  parameter int MAXB  = 8,
  parameter int TRUNC = 0,
  parameter int AW    = W + $clog2(MAXB + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pos,
  input  logic         in_pos_en,
  input  logic [W-1:0] in_neg,
  input  logic         in_neg_en,
  input  logic         in_last,
  input  logic         cmp_ge,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_vote,
  output logic         out_ovf
);
  localparam int CW = $clog2(MAXB + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state;
  logic [AW-1:0] psum, nsum;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          accept, idle;
  logic [AW-1:0] p_base, n_base, p_add, n_add, p_nxt, n_nxt;
  logic [AW:0]   p_wide, n_wide;
  logic          p_sat, n_sat;
  logic [CW-1:0] cnt_nxt;
  logic          max_hit, close, ovf_nxt, vote_nxt;

  assign accept = in_valid && in_ready;
  assign idle   = (state == IDLE);

  // IDLE starts from zero so stale sums never leak into a new vote.
  always_comb begin
    p_base   = idle ? '0 : psum;
    n_base   = idle ? '0 : nsum;
    p_add    = in_pos_en ? AW'(in_pos >> TRUNC) : '0;
    n_add    = in_neg_en ? AW'(in_neg >> TRUNC) : '0;
    p_wide   = {1'b0, p_base} + {1'b0, p_add};
    n_wide   = {1'b0, n_base} + {1'b0, n_add};
    p_sat    = p_wide[AW];
    n_sat    = n_wide[AW];
    p_nxt    = p_sat ? '1 : p_wide[AW-1:0];
    n_nxt    = n_sat ? '1 : n_wide[AW-1:0];
    cnt_nxt  = (idle ? '0 : cnt) + CW'(1);
    max_hit  = (cnt_nxt == CW'(MAXB));
    close    = in_last || max_hit;
    ovf_nxt  = (!idle && ovf) || p_sat || n_sat || (max_hit && !in_last);
    vote_nxt = cmp_ge ? (p_nxt >= n_nxt) : (p_nxt > n_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      psum      <= '0;
      nsum      <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_vote  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          in_ready <= 1'b1;
          if (accept) begin
            psum <= p_nxt;
            nsum <= n_nxt;
            cnt  <= cnt_nxt;
            ovf  <= ovf_nxt;
            if (close) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_vote  <= vote_nxt;
              out_ovf   <= ovf_nxt;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            psum      <= '0;
            nsum      <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_vote  <= 1'b0;
            out_ovf   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tnn_vote_seq.sv
// Directed bench for tnn_vote_seq: default, MAXB=4 and TRUNC=1/AW=2 instances.
module tb_tnn_vote_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv   [3];
  logic [1:0] pos  [3];
  logic       pen  [3];
  logic [1:0] neg  [3];
  logic       nen  [3];
  logic       lst  [3];
  logic       ge   [3];
  logic       ordy [3];
  logic       irdy [3];
  logic       ov   [3];
  logic       vote [3];
  logic       ovf  [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tnn_vote_seq #(.W(2), .MAXB(8), .TRUNC(0)) u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_pos(pos[0]), .in_pos_en(pen[0]), .in_neg(neg[0]), .in_neg_en(nen[0]),
    .in_last(lst[0]), .cmp_ge(ge[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_vote(vote[0]), .out_ovf(ovf[0]));

  tnn_vote_seq #(.W(2), .MAXB(4), .TRUNC(0)) u_max4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_pos(pos[1]), .in_pos_en(pen[1]), .in_neg(neg[1]), .in_neg_en(nen[1]),
    .in_last(lst[1]), .cmp_ge(ge[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_vote(vote[1]), .out_ovf(ovf[1]));

  tnn_vote_seq #(.W(2), .MAXB(8), .TRUNC(1), .AW(2)) u_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_pos(pos[2]), .in_pos_en(pen[2]), .in_neg(neg[2]), .in_neg_en(nen[2]),
    .in_last(lst[2]), .cmp_ge(ge[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_vote(vote[2]), .out_ovf(ovf[2]));

  typedef struct {
    int         d;
    logic [1:0] p;
    logic       pe;
    logic [1:0] n;
    logic       ne;
    logic       l;
    logic       g;
    logic       ev;
    logic       eo;
  } row_t;

  localparam int NROWS = 19;
  row_t tbl [NROWS];

  task automatic chk(input string nm, input int d, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", nm, d, a, e, $time);
    end
  endtask

  // Called at posedge+1; presents one beat across the next edge.
  task automatic beat(input int d, input logic [1:0] p, input logic pe,
                      input logic [1:0] n, input logic ne, input logic l, input logic g);
    iv[d] = 1'b1; pos[d] = p; pen[d] = pe; neg[d] = n; nen[d] = ne; lst[d] = l; ge[d] = g;
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic handshake(input int d);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk("hs_valid_drop", d, ov[d], 1'b0);
    chk("hs_ready_back", d, irdy[d], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; pos[i] = 0; pen[i] = 0; neg[i] = 0; nen[i] = 0;
      lst[i] = 0; ge[i] = 0; ordy[i] = 0;
    end

    //            d  p    pe  n    ne  l  g  ev eo
    tbl[0]  = '{0, 2'd3, 1, 2'd2, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 2'd2, 1, 2'd2, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 2'd1, 1, 2'd1, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 2'd0, 0, 2'd1, 1, 1, 0, 0, 0};
    tbl[4]  = '{0, 2'd3, 1, 2'd2, 1, 0, 1, 0, 0};
    tbl[5]  = '{0, 2'd2, 1, 2'd2, 1, 0, 1, 0, 0};
    tbl[6]  = '{0, 2'd1, 1, 2'd1, 1, 0, 1, 0, 0};
    tbl[7]  = '{0, 2'd0, 0, 2'd1, 1, 1, 1, 1, 0};
    tbl[8]  = '{0, 2'd1, 1, 2'd0, 1, 1, 0, 1, 0};
    tbl[9]  = '{0, 2'd3, 0, 2'd3, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 2'd1, 1, 2'd0, 0, 1, 0, 1, 0};
    tbl[11] = '{0, 2'd1, 1, 2'd3, 1, 1, 1, 0, 0};
    tbl[12] = '{2, 2'd3, 1, 2'd2, 1, 0, 0, 0, 0};
    tbl[13] = '{2, 2'd3, 1, 2'd2, 1, 0, 0, 0, 0};
    tbl[14] = '{2, 2'd0, 0, 2'd2, 1, 1, 0, 0, 0};
    tbl[15] = '{2, 2'd3, 1, 2'd2, 1, 0, 1, 0, 0};
    tbl[16] = '{2, 2'd3, 1, 2'd2, 1, 0, 1, 0, 0};
    tbl[17] = '{2, 2'd3, 1, 2'd2, 1, 0, 1, 0, 0};
    tbl[18] = '{2, 2'd3, 1, 2'd0, 0, 1, 1, 1, 1};

    // Reset state: every output low while rst_n is held.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", i, irdy[i], 1'b0);
      chk("rst_out_valid", i, ov[i], 1'b0);
      chk("rst_out_vote", i, vote[i], 1'b0);
      chk("rst_out_ovf", i, ovf[i], 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk("post_rst_ready", i, irdy[i], 1'b1);

    // Table-driven votes.
    for (int r = 0; r < NROWS; r++) begin
      beat(tbl[r].d, tbl[r].p, tbl[r].pe, tbl[r].n, tbl[r].ne, tbl[r].l, tbl[r].g);
      if (tbl[r].l) begin
        chk("vote_valid", tbl[r].d, ov[tbl[r].d], 1'b1);
        chk("vote_result", tbl[r].d, vote[tbl[r].d], tbl[r].ev);
        chk("vote_ovf", tbl[r].d, ovf[tbl[r].d], tbl[r].eo);
        chk("done_not_ready", tbl[r].d, irdy[tbl[r].d], 1'b0);
        handshake(tbl[r].d);
      end else begin
        chk("mid_no_valid", tbl[r].d, ov[tbl[r].d], 1'b0);
        chk("mid_ready", tbl[r].d, irdy[tbl[r].d], 1'b1);
      end
    end

    // MAXB=4 force-close, then a fifth beat stalled under backpressure.
    for (int b = 0; b < 4; b++) beat(1, 2'd3, 1, 2'd0, 0, 0, 0);
    chk("maxb_valid", 1, ov[1], 1'b1);
    chk("maxb_ovf", 1, ovf[1], 1'b1);
    chk("maxb_vote", 1, vote[1], 1'b1);
    chk("maxb_not_ready", 1, irdy[1], 1'b0);
    iv[1] = 1'b1; pos[1] = 2'd3; pen[1] = 1'b1; lst[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_ready", 1, irdy[1], 1'b0);
      chk("hold_valid", 1, ov[1], 1'b1);
      chk("hold_vote", 1, vote[1], 1'b1);
      chk("hold_ovf", 1, ovf[1], 1'b1);
    end
    ordy[1] = 1'b1;
    @(posedge clk); #1;
    ordy[1] = 1'b0;
    iv[1] = 1'b0;
    chk("release_valid", 1, ov[1], 1'b0);
    chk("release_ready", 1, irdy[1], 1'b1);
    // Next vote must start from cleared sums and cleared ovf: 0 > 0 is false.
    beat(1, 2'd0, 1, 2'd0, 1, 1, 0);
    chk("after_maxb_valid", 1, ov[1], 1'b1);
    chk("after_maxb_vote", 1, vote[1], 1'b0);
    chk("after_maxb_ovf", 1, ovf[1], 1'b0);
    handshake(1);

    // Reset dropped during the second beat of a vote.
    beat(0, 2'd3, 1, 2'd0, 0, 0, 0);
    iv[0] = 1'b1; pos[0] = 2'd2; pen[0] = 1'b1; nen[0] = 1'b0; lst[0] = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 0, irdy[0], 1'b0);
    chk("midrst_valid", 0, ov[0], 1'b0);
    chk("midrst_vote", 0, vote[0], 1'b0);
    chk("midrst_ovf", 0, ovf[0], 1'b0);
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("postrst_no_pulse", 0, ov[0], 1'b0);
    end
    chk("postrst_ready", 0, irdy[0], 1'b1);
    // Stale psum of 3 would make 1 > 1 true.
    beat(0, 2'd1, 1, 2'd1, 1, 1, 0);
    chk("postrst_valid", 0, ov[0], 1'b1);
    chk("postrst_vote", 0, vote[0], 1'b0);
    chk("postrst_ovf", 0, ovf[0], 1'b0);
    handshake(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
